nios2_ls_timer_multi: RTL and testbench



---
 rtl/nios2_ls_timer_multi.sv | 178 +++++++++++++++++
 tb/tb_nios2_ls_timer_multi.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_ls_timer_multi.sv
// nios2_ls_timer_multi
//
// Multi-channel interval timer behind a 16-bit Avalon-MM slave. NUM_CH
// independent down-counters each have a prescaler, a one-shot or continuous
// mode, a snapshot register and an interrupt enable. The channel interrupts
// are ORed onto irq. A pending-vector register, readable in every channel
// slot, lets an ISR find the source with a single read.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   address    [ADDR_WIDTH-1:3] channel, [2:0] register offset
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  16-bit write data
//   readdata   registered read data, one cycle after the address
//   irq        OR over channels of (TO & ITO)
//
// Register offsets per channel:
//   0 STATUS   {RUN, TO}; any write clears TO
//   1 CONTROL  {STOP, START, CONT, ITO}; START/STOP also act as strobes
//   2 PERIOD_L 3 PERIOD_H  4 SNAP_L  5 SNAP_H  6 PRESCALE  7 PENDING
module nios2_ls_timer_multi #(
    parameter int NUM_CH         = 4,
    parameter int COUNTER_WIDTH  = 32,
    parameter int PRESCALE_WIDTH = 8,
    parameter int RESET_PERIOD   = 49999,
    parameter int ADDR_WIDTH     = 3 + $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [15:0]           writedata,
    output logic [15:0]           readdata,
    output logic                  irq
);

    localparam int CW   = COUNTER_WIDTH;
    localparam int PW   = PRESCALE_WIDTH;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CW-1:0]     cnt     [NUM_CH];
    logic [CW-1:0]     per     [NUM_CH];
    logic [CW-1:0]     snap    [NUM_CH];
    logic [3:0]        ctrl    [NUM_CH];
    logic [PW-1:0]     pre_cnt [NUM_CH];
    logic [PW-1:0]     prescale[NUM_CH];
    logic [NUM_CH-1:0] to;
    logic [NUM_CH-1:0] run;
    logic [NUM_CH-1:0] reload;

    logic [CH_W-1:0]   ch_sel;
    logic              ch_ok;
    logic [2:0]        off;
    logic              wstb;
    logic [NUM_CH-1:0] wr;
    logic [NUM_CH-1:0] per_wr;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pend;
    logic [15:0]       rd_mux;

    // With a single channel there is no channel field in the address.
    generate
        if (NUM_CH > 1) begin : g_multi
            assign ch_sel = address[ADDR_WIDTH-1:3];
            assign ch_ok  = (32'(ch_sel) < NUM_CH);
        end else begin : g_single
            assign ch_sel = '0;
            assign ch_ok  = 1'b1;
        end
    endgenerate

    assign off  = address[2:0];
    assign wstb = chipselect & ~write_n & ch_ok;

    always_comb begin
        wr     = '0;
        per_wr = '0;
        tick   = '0;
        pend   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            wr[k]     = wstb && (32'(ch_sel) == k);
            per_wr[k] = wr[k] && (off == 3'd2 || off == 3'd3);
            tick[k]   = run[k] && (pre_cnt[k] == prescale[k]);
            pend[k]   = to[k] & ctrl[k][0];
        end
    end

    assign irq = |pend;

    always_comb begin
        rd_mux = '0;
        if (ch_ok) begin
            case (off)
                3'd0:    rd_mux = {14'b0, run[ch_sel], to[ch_sel]};
                3'd1:    rd_mux = {12'b0, ctrl[ch_sel]};
                3'd2:    rd_mux = per[ch_sel][15:0];
                3'd3:    rd_mux = 16'(per[ch_sel] >> 16);
                3'd4:    rd_mux = snap[ch_sel][15:0];
                3'd5:    rd_mux = 16'(snap[ch_sel] >> 16);
                3'd6:    rd_mux = 16'(prescale[ch_sel]);
                default: rd_mux = 16'(pend);
            endcase
        end
    end

    // Register stage: read data and all channel state.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
            to       <= '0;
            run      <= '0;
            reload   <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                cnt[k]      <= CW'(RESET_PERIOD);
                per[k]      <= CW'(RESET_PERIOD);
                snap[k]     <= '0;
                ctrl[k]     <= '0;
                pre_cnt[k]  <= '0;
                prescale[k] <= '0;
            end
        end else begin
            readdata <= rd_mux;
            for (int k = 0; k < NUM_CH; k++) begin
                // Prescaler restarts from zero whenever the channel is idle
                // or its period changes, so the next interval is whole.
                if (!run[k] || per_wr[k] || tick[k])
                    pre_cnt[k] <= '0;
                else
                    pre_cnt[k] <= pre_cnt[k] + PW'(1);

                // The clear is assigned before the timeout so a timeout in
                // the same cycle overrides it and the event is kept.
                if (wr[k] && off == 3'd0)
                    to[k] <= 1'b0;

                if (tick[k]) begin
                    if (cnt[k] != '0) begin
                        cnt[k] <= cnt[k] - CW'(1);
                    end else begin
                        cnt[k] <= per[k];
                        to[k]  <= 1'b1;
                        if (!ctrl[k][1])
                            run[k] <= 1'b0;
                    end
                end

                // Reload happens the cycle after a period write so that the
                // freshly written half is already in per[k].
                reload[k] <= per_wr[k];
                if (reload[k]) begin
                    cnt[k] <= per[k];
                    run[k] <= 1'b0;
                end

                if (wr[k]) begin
                    case (off)
                        3'd1: begin
                            ctrl[k] <= writedata[3:0];
                            if (writedata[2])
                                run[k] <= 1'b1;
                            else if (writedata[3])
                                run[k] <= 1'b0;
                        end
                        3'd2:       per[k][15:0]    <= writedata;
                        3'd3:       per[k][CW-1:16] <= writedata[CW-17:0];
                        3'd4, 3'd5: snap[k]         <= cnt[k];
                        3'd6:       prescale[k]     <= writedata[PW-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_nios2_ls_timer_multi.sv
module tb_nios2_ls_timer_multi;

    localparam int NCH = 4;
    localparam int AW  = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] address;
    logic          chipselect;
    logic          write_n;
    logic [15:0]   writedata;
    logic [15:0]   readdata;
    logic          irq;

    nios2_ls_timer_multi #(
        .NUM_CH(4), .COUNTER_WIDTH(32), .PRESCALE_WIDTH(8), .RESET_PERIOD(49999)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        int          kind;   // 0 readdata, 1 irq
        int          ch;
        int          off;
        logic [15:0] exp;
    } sb_t;
    sb_t sb[$];

    // Reference model: timer state per channel as the register map describes it.
    logic [31:0] m_cnt [NCH];
    logic [31:0] m_per [NCH];
    logic [31:0] m_snap[NCH];
    logic [3:0]  m_ctrl[NCH];
    logic [7:0]  m_pre [NCH];
    logic [7:0]  m_ps  [NCH];
    bit          m_to  [NCH];
    bit          m_run [NCH];
    bit          m_rel [NCH];

    function automatic logic [15:0] m_pending();
        logic [15:0] v;
        v = 16'h0;
        for (int k = 0; k < NCH; k++)
            if (m_to[k] && m_ctrl[k][0]) v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [15:0] m_read(input int ch, input int off);
        case (off)
            0: return {14'b0, m_run[ch], m_to[ch]};
            1: return {12'b0, m_ctrl[ch]};
            2: return m_per[ch][15:0];
            3: return m_per[ch][31:16];
            4: return m_snap[ch][15:0];
            5: return m_snap[ch][31:16];
            6: return {8'b0, m_ps[ch]};
            default: return m_pending();
        endcase
    endfunction

    task automatic model_step(input bit r, input bit we, input int ch, input int off,
                              input logic [15:0] d, output logic [15:0] rd, output logic irq_o);
        if (r) begin
            for (int k = 0; k < NCH; k++) begin
                m_cnt[k] = 49999; m_per[k] = 49999; m_snap[k] = 0; m_ctrl[k] = 0;
                m_pre[k] = 0; m_ps[k] = 0; m_to[k] = 0; m_run[k] = 0; m_rel[k] = 0;
            end
            rd = 16'h0;
        end else begin
            rd = m_read(ch, off);
            for (int k = 0; k < NCH; k++) begin
                bit hit, fires, expire, pw, t, rn;
                logic [31:0] c;
                logic [7:0]  p;
                hit    = we && (k == ch);
                fires  = m_run[k] && (m_pre[k] == m_ps[k]);
                expire = fires && (m_cnt[k] == 0);
                pw     = hit && (off == 2 || off == 3);
                c = m_cnt[k]; t = m_to[k]; rn = m_run[k];
                p = (!m_run[k] || fires || pw) ? 8'd0 : m_pre[k] + 8'd1;
                if (expire) begin
                    c = m_per[k]; t = 1'b1;
                    if (!m_ctrl[k][1]) rn = 1'b0;
                end else if (fires) begin
                    c = m_cnt[k] - 1;
                end
                if (hit && off == 0 && !expire) t = 1'b0;
                if (m_rel[k]) begin c = m_per[k]; rn = 1'b0; end
                if (hit && (off == 4 || off == 5)) m_snap[k] = m_cnt[k];
                if (hit && off == 1) begin
                    m_ctrl[k] = d[3:0];
                    if (d[2]) rn = 1'b1;
                    else if (d[3]) rn = 1'b0;
                end
                if (hit && off == 2) m_per[k][15:0]  = d;
                if (hit && off == 3) m_per[k][31:16] = d;
                if (hit && off == 6) m_ps[k] = d[7:0];
                m_rel[k] = pw; m_cnt[k] = c; m_to[k] = t; m_run[k] = rn; m_pre[k] = p;
            end
        end
        irq_o = (m_pending() != 16'h0);
    endtask

    // One bus cycle. readdata and irq are scored after every edge; a constant
    // expectation replaces the model's read value when use_k is set.
    task automatic cycle(input bit r, input bit cs, input bit we, input int ch, input int off,
                         input logic [15:0] d, input bit use_k, input logic [15:0] k);
        logic [15:0] rd_e;
        logic        irq_e;
        logic [1:0]  chb;
        logic [2:0]  ofb;
        chb = ch[1:0];
        ofb = off[2:0];
        reset = r; chipselect = cs; write_n = !we; address = {chb, ofb}; writedata = d;
        @(posedge clk);
        model_step(r, cs && we, ch, off, d, rd_e, irq_e);
        cyc++;
        sb.push_back('{cyc, 0, ch, off, use_k ? k : rd_e});
        sb.push_back('{cyc, 1, ch, off, {15'b0, irq_e}});
        #1;
    endtask

    task automatic wr(input int ch, input int off, input logic [15:0] d);
        cycle(1'b0, 1'b1, 1'b1, ch, off, d, 1'b0, 16'h0);
    endtask
    task automatic rdm(input int ch, input int off);
        cycle(1'b0, 1'b1, 1'b0, ch, off, 16'h0, 1'b0, 16'h0);
    endtask
    task automatic rdk(input int ch, input int off, input logic [15:0] k);
        cycle(1'b0, 1'b1, 1'b0, ch, off, 16'h0, 1'b1, k);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0, 0, 16'h0, 1'b0, 16'h0);
    endtask

    // Monitor: scores every queued expectation whose cycle has been reached.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                sb_t e;
                logic [15:0] act;
                e = sb.pop_front();
                act = (e.kind == 1) ? {15'b0, irq} : readdata;
                checks++;
                if (act !== e.exp) begin
                    failures++;
                    if (e.kind == 1)
                        $display("FAIL irq cyc=%0d got=%0b want=%0b", e.cyc, act[0], e.exp[0]);
                    else
                        $display("FAIL readdata ch%0d reg%0d cyc=%0d got=0x%04h want=0x%04h",
                                 e.ch, e.off, e.cyc, act, e.exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 0, 0, 16'h0, 1'b1, 16'h0);

        // Reset values through the read path.
        rdk(0, 2, 16'hC34F);
        rdk(0, 3, 16'h0000);
        rdk(0, 0, 16'h0000);

        // ch1: period 9, continuous, irq enabled; timeout every 10 clocks.
        wr(1, 2, 16'd9); wr(1, 3, 16'd0); wr(1, 6, 16'd0); wr(1, 1, 16'h0007);
        idle(9);
        rdk(1, 0, 16'h0002);          // edge 10: still counting, TO not yet set
        rdk(1, 0, 16'h0003);          // TO set, still running
        rdk(1, 7, 16'h0002);          // pending vector
        wr(1, 0, 16'h0000);           // clear TO
        rdk(1, 0, 16'h0002);
        idle(5);
        rdk(1, 7, 16'h0000);          // edge 20
        rdk(1, 7, 16'h0002);          // re-asserted after next timeout
        idle(8);
        wr(1, 0, 16'h0000);           // clear in the same cycle as timeout at edge 30
        rdk(1, 0, 16'h0003);
        wr(1, 1, 16'h000C);           // START|STOP: START wins
        rdk(1, 0, 16'h0003);
        rdk(1, 1, 16'h000C);

        // ch2: period 4, prescale 3, one-shot; timeout 20 clocks after START.
        wr(2, 2, 16'd4); wr(2, 3, 16'd0); wr(2, 6, 16'd3); wr(2, 1, 16'h0005);
        idle(19);
        rdk(2, 0, 16'h0002);
        rdk(2, 0, 16'h0001);
        wr(2, 4, 16'h0000);
        rdk(2, 4, 16'h0004);
        rdk(2, 5, 16'h0000);
        rdk(2, 7, 16'h0004);

        // ch3: period 0x10000, snapshot mid-count, then period change mid-run.
        wr(3, 2, 16'h0000); wr(3, 3, 16'h0001); wr(3, 6, 16'h0000); wr(3, 1, 16'h0004);
        idle(5);
        wr(3, 4, 16'h0000);
        rdk(3, 5, 16'h0000);
        rdk(3, 4, 16'hFFFB);
        wr(3, 3, 16'h0002);
        idle(1);
        rdk(3, 0, 16'h0000);
        wr(3, 4, 16'h0000);
        rdk(3, 5, 16'h0002);
        rdk(3, 4, 16'h0000);

        // Reset while every channel is counting, with a write on the bus.
        for (int k = 0; k < NCH; k++) wr(k, 1, 16'h0007);
        idle(12);
        cycle(1'b1, 1'b1, 1'b1, 1, 1, 16'h0007, 1'b1, 16'h0000);
        for (int k = 0; k < NCH; k++)
            for (int o = 0; o < 8; o++)
                rdk(k, o, (o == 2) ? 16'hC34F : 16'h0000);

        // Randomised traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            int sel, ch, off;
            logic [15:0] d;
            sel = $urandom_range(0, 9);
            ch  = $urandom_range(0, NCH - 1);
            off = $urandom_range(0, 7);
            d   = 16'($urandom);
            if (sel < 3) begin
                case (off)
                    2: d = 16'($urandom_range(0, 20));
                    3: d = ($urandom_range(0, 7) == 0) ? 16'd1 : 16'd0;
                    6: d = {d[15:8], 8'($urandom_range(0, 3))};
                    default: ;
                endcase
                wr(ch, off, d);
            end else if (sel < 6) begin
                rdm(ch, off);
            end else begin
                cycle(1'b0, 1'b0, 1'b0, ch, off, d, 1'b0, 16'h0);
            end
        end

        idle(2);
        #5;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
